// File: rtl/stim_seq_chsel.sv
// ---------------------------------------------------------------------------
// stim_seq_chsel
//   Biphasic stimulus sequencer.  Drives the stimulator current DAC (EN_ST,
//   MAG_ST) and the high-side / low-side channel switch matrix.  It produces
//   rest / anodic / inter-pulse-delay / cathodic trains with runtime phase
//   timing, an optional pairwise channel sweep and an optional magnitude ramp.
//
//   Optional feature macro: STIM_RAMP_EN
//     defined   : RAMP=1 starts MAG_ST at 0 and steps it by one at every train
//                 end, saturating at the captured MAG_CFG.
//     undefined : no ramp logic; RAMP is ignored and MAG_ST = MAG_CFG while busy.
//
// Ports
//   CLK         in   sequencer clock
//   RST         in   asynchronous active-high reset
//   START       in   1-cycle start strobe, honoured only in IDLE
//   STOP        in   1-cycle stop request
//   SWEEP       in   1: sweep pairs (0,1),(2,3)...; 0: fixed CH_ANO / CH_CAT
//   RAMP        in   1: ramp MAG_ST from 0 up to MAG_CFG (ramp build only)
//   MAG_CFG     in   target magnitude code
//   CH_ANO      in   anodic-phase high-side channel (SWEEP=0)
//   CH_CAT      in   cathodic-phase high-side channel (SWEEP=0)
//   T_REST_US   in   rest duration, us (0 behaves as 1)
//   T_ANO_US    in   anodic duration, us
//   T_IPD_US    in   inter-pulse delay, us
//   T_CAT_US    in   cathodic duration, us
//   EN_ST       out  current source enable, high only in ANO and CAT
//   MAG_ST      out  current magnitude code
//   ChSel_HS    out  high-side switch select
//   ChSel_LS    out  low-side switch select
//   BUSY        out  high in every state except IDLE
//   PULSE_DONE  out  strobe on the last cycle of every cathodic phase
// ---------------------------------------------------------------------------
module stim_seq_chsel #(
  parameter int  NCH          = 8,
  parameter int  MAG_W        = 5,
  parameter int  TW           = 12,
  parameter int  CLK_PER_US   = 10,
  parameter int  SWEEP_GAP_US = 1000,
  localparam int CH_W         = $clog2(NCH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic             SWEEP,
  input  logic             RAMP,
  input  logic [MAG_W-1:0] MAG_CFG,
  input  logic [CH_W-1:0]  CH_ANO,
  input  logic [CH_W-1:0]  CH_CAT,
  input  logic [TW-1:0]    T_REST_US,
  input  logic [TW-1:0]    T_ANO_US,
  input  logic [TW-1:0]    T_IPD_US,
  input  logic [TW-1:0]    T_CAT_US,
  output logic             EN_ST,
  output logic [MAG_W-1:0] MAG_ST,
  output logic [CH_W-1:0]  ChSel_HS,
  output logic [CH_W-1:0]  ChSel_LS,
  output logic             BUSY,
  output logic             PULSE_DONE
);

  // Prescaler counts CLK cycles within one us; the us counter counts whole us.
  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int GW = $clog2(SWEEP_GAP_US + 1);
  localparam int UW = (TW > GW) ? TW : GW;

  localparam logic [PW-1:0]   PRE_RELOAD = PW'(CLK_PER_US - 1);
  localparam logic [UW-1:0]   GAP_RELOAD = UW'(SWEEP_GAP_US - 1);
  localparam logic [CH_W-1:0] PAIR_LAST  = CH_W'(NCH / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REST, S_ANO, S_IPD, S_CAT, S_GAP
  } state_t;

  state_t          state;
  logic [PW-1:0]   pre;
  logic [UW-1:0]   us;
  logic [UW-1:0]   next_us;
  logic            cnt_last;
  logic            cnt_penult;
  logic            cat_one_cycle;

  // Configuration captured at START; inputs are not looked at again while busy.
  logic            sweep_r;
  logic [CH_W-1:0] ch_ano_r;
  logic [CH_W-1:0] ch_cat_r;
  logic [TW-1:0]   t_rest_r;
  logic [TW-1:0]   t_ano_r;
  logic [TW-1:0]   t_ipd_r;
  logic [TW-1:0]   t_cat_r;
  logic [CH_W-1:0] pair;
  logic            stop_pending;
  logic [CH_W-1:0] chan_a;
  logic [CH_W-1:0] chan_c;
  logic [MAG_W-1:0] mag_next;

`ifdef STIM_RAMP_EN
  logic             ramp_r;
  logic [MAG_W-1:0] mag_cfg_r;

  // Train-end magnitude step, saturating at the captured target.
  assign mag_next = (ramp_r && (MAG_ST < mag_cfg_r)) ? MAG_ST + MAG_W'(1) : MAG_ST;
`else
  logic unused_ramp;

  assign unused_ramp = RAMP;
  assign mag_next    = MAG_ST;
`endif

  // A duration of 0 us is stretched to 1 us, so its reload value is 0 as well.
  function automatic logic [UW-1:0] us_reload(input logic [TW-1:0] t);
    if (t == '0) return '0;
    return UW'(t - TW'(1));
  endfunction

  assign cnt_last      = (pre == '0) && (us == '0);
  // True one cycle before cnt_last while the phase keeps running.
  assign cnt_penult    = ((pre == PW'(1)) && (us == '0)) ||
                         ((CLK_PER_US == 1) && (us == UW'(1)));
  // A cathodic phase of a single cycle needs its done strobe armed from IPD.
  assign cat_one_cycle = (CLK_PER_US == 1) && (t_cat_r <= TW'(1));

  assign chan_a = sweep_r ? CH_W'({pair, 1'b0}) : ch_ano_r;
  assign chan_c = sweep_r ? CH_W'({pair, 1'b1}) : ch_cat_r;

  // Duration of the phase that follows the current one.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_us = us_reload(t_rest_r);
    case (state)
      S_IDLE:  next_us = us_reload(T_REST_US);
      S_REST:  next_us = us_reload(t_ano_r);
      S_ANO:   next_us = us_reload(t_ipd_r);
      S_IPD:   next_us = us_reload(t_cat_r);
      S_CAT:   next_us = (sweep_r && (pair == PAIR_LAST)) ? GAP_RELOAD : us_reload(t_rest_r);
      default: next_us = us_reload(t_rest_r);
    endcase
  end

  // Phase timer: reloads continuously in IDLE and on the last cycle of every
  // phase, so each state starts with a fresh prescaler and us count.
  // NOTE: sequential state uses non-blocking assignments only, so every block
  // sees the pre-edge value of every register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre <= '0;
      us  <= '0;
    end else if ((state == S_IDLE) || cnt_last) begin
      pre <= PRE_RELOAD;
      us  <= next_us;
    end else if (pre == '0) begin
      pre <= PRE_RELOAD;
      us  <= us - UW'(1);
    end else begin
      pre <= pre - PW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      EN_ST        <= 1'b0;
      MAG_ST       <= '0;
      ChSel_HS     <= '0;
      ChSel_LS     <= '0;
      BUSY         <= 1'b0;
      PULSE_DONE   <= 1'b0;
      sweep_r      <= 1'b0;
      ch_ano_r     <= '0;
      ch_cat_r     <= '0;
      t_rest_r     <= '0;
      t_ano_r      <= '0;
      t_ipd_r      <= '0;
      t_cat_r      <= '0;
      pair         <= '0;
      stop_pending <= 1'b0;
`ifdef STIM_RAMP_EN
      ramp_r       <= 1'b0;
      mag_cfg_r    <= '0;
`endif
    end else begin
      PULSE_DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START && !STOP) begin
            state        <= S_REST;
            BUSY         <= 1'b1;
            sweep_r      <= SWEEP;
            ch_ano_r     <= CH_ANO;
            ch_cat_r     <= CH_CAT;
            t_rest_r     <= T_REST_US;
            t_ano_r      <= T_ANO_US;
            t_ipd_r      <= T_IPD_US;
            t_cat_r      <= T_CAT_US;
            pair         <= '0;
            stop_pending <= 1'b0;
`ifdef STIM_RAMP_EN
            ramp_r       <= RAMP;
            mag_cfg_r    <= MAG_CFG;
            MAG_ST       <= RAMP ? '0 : MAG_CFG;
`else
            MAG_ST       <= MAG_CFG;
`endif
          end
        end

        S_REST: begin
          if (STOP) begin
            state  <= S_IDLE;
            BUSY   <= 1'b0;
            MAG_ST <= '0;
          end else if (cnt_last) begin
            state    <= S_ANO;
            EN_ST    <= 1'b1;
            ChSel_HS <= chan_a;
            ChSel_LS <= chan_c;
          end
        end

        S_ANO: begin
          if (STOP) stop_pending <= 1'b1;
          if (cnt_last) begin
            state <= S_IPD;
            EN_ST <= 1'b0;
          end
        end

        S_IPD: begin
          if (STOP) stop_pending <= 1'b1;
          if (cnt_last) begin
            state      <= S_CAT;
            EN_ST      <= 1'b1;
            ChSel_HS   <= chan_c;
            ChSel_LS   <= chan_a;
            PULSE_DONE <= cat_one_cycle;
          end
        end

        S_CAT: begin
          // A stop never cuts the cathodic phase short: charge balance first.
          if (cnt_last) begin
            EN_ST <= 1'b0;
            if (STOP || stop_pending) begin
              state        <= S_IDLE;
              BUSY         <= 1'b0;
              MAG_ST       <= '0;
              stop_pending <= 1'b0;
            end else if (sweep_r && (pair == PAIR_LAST)) begin
              state <= S_GAP;
              pair  <= '0;
            end else if (sweep_r) begin
              state <= S_REST;
              pair  <= pair + CH_W'(1);
            end else begin
              state  <= S_REST;
              MAG_ST <= mag_next;
            end
          end else begin
            if (STOP) stop_pending <= 1'b1;
            PULSE_DONE <= cnt_penult;
          end
        end

        S_GAP: begin
          if (STOP) begin
            state  <= S_IDLE;
            BUSY   <= 1'b0;
            MAG_ST <= '0;
          end else if (cnt_last) begin
            state  <= S_REST;
            MAG_ST <= mag_next;
          end
        end

        default: begin
          state  <= S_IDLE;
          EN_ST  <= 1'b0;
          BUSY   <= 1'b0;
          MAG_ST <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stim_seq_chsel.sv
// ---------------------------------------------------------------------------
// tb_stim_seq_chsel
//   Self-checking bench for stim_seq_chsel (CLK_PER_US=2, NCH=8,
//   SWEEP_GAP_US=4).  A phase-level reference model (phase name plus cycles
//   left in it) predicts every output on every cycle; directed scenarios add
//   hand-computed literal expectations, then a randomized run follows.
// ---------------------------------------------------------------------------
module tb_stim_seq_chsel;

  localparam int CPU  = 2;
  localparam int NCHT = 8;
  localparam int GAPU = 4;

  localparam int P_IDLE = 0;
  localparam int P_REST = 1;
  localparam int P_ANO  = 2;
  localparam int P_IPD  = 3;
  localparam int P_CAT  = 4;
  localparam int P_GAP  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        sweep = 1'b0;
  logic        ramp = 1'b0;
  logic [4:0]  mag_cfg = '0;
  logic [2:0]  ch_ano = '0;
  logic [2:0]  ch_cat = '0;
  logic [11:0] t_rest = '0;
  logic [11:0] t_ano = '0;
  logic [11:0] t_ipd = '0;
  logic [11:0] t_cat = '0;
  logic        en_st;
  logic [4:0]  mag_st;
  logic [2:0]  hs;
  logic [2:0]  ls;
  logic        busy;
  logic        pulse_done;

  int n_err = 0;
  int n_chk = 0;
  int cur   = 0;

  stim_seq_chsel #(
    .NCH(NCHT), .MAG_W(5), .TW(12), .CLK_PER_US(CPU), .SWEEP_GAP_US(GAPU)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop), .SWEEP(sweep), .RAMP(ramp),
    .MAG_CFG(mag_cfg), .CH_ANO(ch_ano), .CH_CAT(ch_cat),
    .T_REST_US(t_rest), .T_ANO_US(t_ano), .T_IPD_US(t_ipd), .T_CAT_US(t_cat),
    .EN_ST(en_st), .MAG_ST(mag_st), .ChSel_HS(hs), .ChSel_LS(ls),
    .BUSY(busy), .PULSE_DONE(pulse_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: which phase we are in and how many cycles remain.
  // ------------------------------------------------------------------
  int m_ph = P_IDLE, m_left = 0, m_k = 0, m_mag = 0, m_hs = 0, m_ls = 0;
  int m_sweep = 0, m_ramp = 0, m_cfg = 0, m_ano = 0, m_cat = 0, m_spend = 0;
  int m_t[4];

  function automatic int dur(input int t);
    return ((t == 0) ? 1 : t) * CPU;
  endfunction

  function automatic int m_a();
    return (m_sweep != 0) ? 2 * m_k : m_ano;
  endfunction

  function automatic int m_c();
    return (m_sweep != 0) ? 2 * m_k + 1 : m_cat;
  endfunction

  task automatic m_go_idle();
    m_ph = P_IDLE; m_mag = 0; m_spend = 0;
  endtask

  task automatic m_train_end();
`ifdef STIM_RAMP_EN
    if (m_ramp != 0 && m_mag < m_cfg) m_mag++;
`endif
  endtask

  task automatic model_step();
    if (m_ph == P_IDLE) begin
      if (start && !stop) begin
        m_sweep = int'(sweep); m_ramp = int'(ramp); m_cfg = int'(mag_cfg);
        m_ano = int'(ch_ano); m_cat = int'(ch_cat);
        m_t[0] = int'(t_rest); m_t[1] = int'(t_ano); m_t[2] = int'(t_ipd); m_t[3] = int'(t_cat);
        m_k = 0; m_spend = 0;
`ifdef STIM_RAMP_EN
        m_mag = (m_ramp != 0) ? 0 : m_cfg;
`else
        m_mag = m_cfg;
`endif
        m_ph = P_REST; m_left = dur(m_t[0]);
      end
    end else if ((m_ph == P_REST || m_ph == P_GAP) && stop) begin
      m_go_idle();
    end else begin
      if (stop) m_spend = 1;
      if (m_left > 1) m_left--;
      else begin
        case (m_ph)
          P_REST: begin m_ph = P_ANO; m_left = dur(m_t[1]); m_hs = m_a(); m_ls = m_c(); end
          P_ANO:  begin m_ph = P_IPD; m_left = dur(m_t[2]); end
          P_IPD:  begin m_ph = P_CAT; m_left = dur(m_t[3]); m_hs = m_c(); m_ls = m_a(); end
          P_CAT: begin
            if (m_spend != 0) m_go_idle();
            else if (m_sweep != 0) begin
              if (m_k == NCHT / 2 - 1) begin m_k = 0; m_ph = P_GAP; m_left = GAPU * CPU; end
              else begin m_k++; m_ph = P_REST; m_left = dur(m_t[0]); end
            end else begin
              m_train_end(); m_ph = P_REST; m_left = dur(m_t[0]);
            end
          end
          default: begin m_train_end(); m_ph = P_REST; m_left = dur(m_t[0]); end
        endcase
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = P_IDLE; m_left = 0; m_k = 0; m_mag = 0; m_hs = 0; m_ls = 0; m_spend = 0;
    end else begin
      model_step();
    end
  end

  // One packed comparison of every output on every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      logic [13:0] exp_v, act_v;
      exp_v = {(m_ph == P_ANO || m_ph == P_CAT), (m_ph != P_IDLE),
               (m_ph == P_CAT && m_left == 1), 5'(m_mag), 3'(m_hs), 3'(m_ls)};
      act_v = {en_st, busy, pulse_done, mag_st, hs, ls};
      check("model{en,busy,pd,mag,hs,ls}", 32'(act_v), 32'(exp_v));
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic set_cfg(input logic sw, input logic rp, input logic [4:0] mg,
                         input logic [2:0] ca, input logic [2:0] cc,
                         input int tr, input int ta, input int ti, input int tc);
    sweep = sw; ramp = rp; mag_cfg = mg; ch_ano = ca; ch_cat = cc;
    t_rest = 12'(tr); t_ano = 12'(ta); t_ipd = 12'(ti); t_cat = 12'(tc);
  endtask

  // Returns just after the edge that samples START; negedge index 0 follows.
  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cur = -1;
  endtask

  task automatic go_to(input int n);
    while (cur < n) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic stop_idle();
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("stop_reaches_idle", busy, 0);
  endtask

  int ecnt, pcnt;
  int ramp_exp[5];

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_en", en_st, 0);
    check("rst_busy", busy, 0);
    check("rst_mag", mag_st, 0);
    check("rst_hs", hs, 0);
    check("rst_ls", ls, 0);
    check("rst_pd", pulse_done, 0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fixed channels: 16-cycle period, REST 6 / ANO 4 / IPD 2 / CAT 4
    set_cfg(0, 0, 31, 1, 2, 3, 2, 1, 2);
    do_start();
    ch_ano = 3'd5; t_rest = 12'd0;          // must not be re-sampled while busy
    go_to(0);  check("fix_busy0", busy, 1); check("fix_en0", en_st, 0);
    go_to(5);  check("fix_rest_end", en_st, 0);
    go_to(6);  check("fix_ano_en", en_st, 1); check("fix_ano_hs", hs, 1);
               check("fix_ano_ls", ls, 2);    check("fix_mag", mag_st, 31);
    go_to(10); check("fix_ipd_en", en_st, 0);
    go_to(12); check("fix_cat_en", en_st, 1); check("fix_cat_hs", hs, 2);
               check("fix_cat_ls", ls, 1);
    go_to(14); check("fix_pd_early", pulse_done, 0);
    go_to(15); check("fix_pd_last", pulse_done, 1);
    ecnt = 0; pcnt = 0;
    for (int n = 16; n < 32; n++) begin
      go_to(n);
      ecnt += int'(en_st);
      pcnt += int'(pulse_done);
      if (n == 16) check("fix_hold_hs", hs, 2);
      if (n == 22) check("fix_period_hs", hs, 1);
    end
    check("fix_en_cycles", ecnt, 8);
    check("fix_pd_count", pcnt, 1);
    stop_idle();

    // Sweep: four pairs, then an 8-cycle gap, then pair 0 again
    set_cfg(1, 0, 10, 0, 0, 3, 2, 1, 2);
    do_start();
    for (int k = 0; k < 4; k++) begin
      go_to(6 + 16 * k);  check("swp_ano_hs", hs, 2 * k);     check("swp_ano_ls", ls, 2 * k + 1);
      go_to(12 + 16 * k); check("swp_cat_hs", hs, 2 * k + 1); check("swp_cat_ls", ls, 2 * k);
    end
    ecnt = 0;
    for (int n = 64; n < 72; n++) begin
      go_to(n);
      ecnt += int'(en_st);
      if (n == 68) check("swp_gap_busy", busy, 1);
    end
    check("swp_gap_en", ecnt, 0);
    go_to(77); check("swp_rest_en", en_st, 0);
    go_to(78); check("swp_wrap_en", en_st, 1); check("swp_wrap_hs", hs, 0); check("swp_wrap_ls", ls, 1);
    stop_idle();

    // Stop on the second anodic cycle: pulse still completes
    set_cfg(0, 0, 31, 1, 2, 3, 2, 1, 2);
    do_start();
    go_to(7); stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    go_to(12); check("stp_cat_en", en_st, 1);
    go_to(15); check("stp_cat_last_en", en_st, 1); check("stp_pd", pulse_done, 1);
    go_to(16); check("stp_idle_busy", busy, 0); check("stp_idle_mag", mag_st, 0);
               check("stp_idle_en", en_st, 0);  check("stp_idle_hs", hs, 2);

    // Asynchronous reset mid-cathodic
    do_start();
    go_to(13); check("arst_pre_en", en_st, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_en", en_st, 0);
    check("arst_busy", busy, 0);
    check("arst_hs", hs, 0);
    check("arst_ls", ls, 0);
    check("arst_mag", mag_st, 0);
    @(negedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Magnitude ramp (or a flat MAG_CFG without the ramp build)
`ifdef STIM_RAMP_EN
    ramp_exp = '{0, 1, 2, 3, 3};
`else
    ramp_exp = '{3, 3, 3, 3, 3};
`endif
    set_cfg(0, 1, 3, 1, 2, 3, 2, 1, 2);
    do_start();
    for (int p = 0; p < 5; p++) begin
      go_to(6 + 16 * p);
      check("ramp_mag", mag_st, ramp_exp[p]);
    end
    stop_idle();
    check("ramp_idle_mag", mag_st, 0);
    do_start();
    go_to(6); check("ramp_restart_mag", mag_st, ramp_exp[0]);
    stop_idle();

    // Zero durations: every phase 2 cycles; START while busy ignored
    set_cfg(0, 0, 7, 3, 4, 0, 0, 0, 0);
    do_start();
    go_to(1); check("zero_rest_en", en_st, 0);
    go_to(2); check("zero_ano_en", en_st, 1); check("zero_ano_hs", hs, 3);
    go_to(3); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    go_to(4); check("zero_ipd_en", en_st, 0);
    go_to(6); check("zero_cat_hs", hs, 4);
    go_to(7); check("zero_pd", pulse_done, 1);
    go_to(9); check("zero_rest2_en", en_st, 0);
    go_to(10); check("zero_ano2_en", en_st, 1);
    stop_idle();

    // START and STOP together in IDLE
    @(posedge clk); #1 start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    @(negedge clk); check("startstop_idle", busy, 0);

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      sweep   = 1'($urandom_range(0, 1));
      ramp    = 1'($urandom_range(0, 1));
      mag_cfg = 5'($urandom);
      ch_ano  = 3'($urandom);
      ch_cat  = 3'($urandom);
      t_rest  = 12'($urandom_range(0, 3));
      t_ano   = 12'($urandom_range(0, 3));
      t_ipd   = 12'($urandom_range(0, 3));
      t_cat   = 12'($urandom_range(0, 3));
      start   = ($urandom_range(0, 15) == 0);
      stop    = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 900) == 0) begin
        #2 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
